data_access_unit: RTL and testbench
===================================

# data_access_unit

Load/store initiator between the core's execute stage and the data port of the unified block-RAM memory. The memory reads with one-cycle registered latency and only supports whole-word writes. This unit adds the following on top of that:
- byte and halfword loads with sign or zero extension;
- byte and halfword stores, done as a read-modify-write;
- misalignment and illegal-funct3 detection.

It accepts one request at a time and returns exactly one response per request.

## Interface
Parameters:
- none; data and address width is `WORD_LEN` (32) from consts.vh.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bits are used for B/H.
- resp_valid  out  1  one-cycle pulse; the response is valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address or illegal funct3; valid with resp_valid.
- addr_d  out  32  memory data address, bits [1:0] always 0.
- rdata  in  32  memory read data, valid the cycle after addr_d is presented.
- wen  out  1  memory word write enable.
- wdata  out  32  memory write word.

## Operation
- States: IDLE, RD, RDW, WR, RESP.
- **Accept:** a request is accepted on an edge with `req_valid && req_ready`. The unit latches wen, funct3, addr and wdata. addr_d ← {addr[31:2], 2'b00}.
- **Illegal** requests:
  - funct3 ∈ {011, 110, 111};
  - a store with funct3[2] = 1;
  - H/HU with addr[0] ≠ 0;
  - W with addr[1:0] ≠ 0.
  - These go IDLE→RESP with resp_err = 1 and make no memory access: wen stays 0 and no RD cycle occurs.
- **Load:** IDLE→RD→RDW→RESP.
  - In RDW, select the lane from the latched addr:
    - B/BU: byte k = addr[1:0], bits [8k+7:8k];
    - H/HU: addr[1] selects [31:16] or [15:0].
  - Sign-extend for B/H, zero-extend for BU/HU, pass the word through for W.
  - Register the result into resp_rdata.
- **SW:** IDLE→WR→RESP, with wdata = req_wdata.
- **SB/SH:** IDLE→RD→RDW→WR→RESP.
  - In RDW, the merged word = rdata with the selected lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH). It is registered into wdata.
  - All other lanes keep their rdata values.
- **WR:** `wen = (state == WR) && !rst`, for exactly one cycle, with addr_d and wdata stable.
- **RESP:**
  - resp_valid = 1 for one cycle, then IDLE.
  - resp_rdata and resp_err hold until the next response.
  - For a successful store, resp_rdata = 0 and resp_err = 0.
- req_ready = (state == IDLE) && !rst. req_valid in other states is ignored and no requests are queued.
- **Reset** (any state, including mid-RMW):
  - next state IDLE;
  - resp_valid, resp_err, wen = 0 and resp_rdata, wdata, addr_d = 0;
  - the interrupted request is dropped with no response;
  - a write is never issued in a cycle where rst = 1.

## Timing
- Accept edge = edge 0.
- Load: RD in cycle 1, RDW in cycle 2, resp_valid in cycle 3. That is 3 cycles from acceptance.
- SW: wen in cycle 1, resp_valid in cycle 2.
- SB/SH: RD in cycle 1, RDW in cycle 2, wen in cycle 3, resp_valid in cycle 4.
- Error: resp_valid in cycle 1.
- req_ready returns high in the cycle after resp_valid. Maximum throughput is one load per 4 cycles.
- addr_d is constant from cycle 1 until the return to IDLE.
- Memory contract: the memory samples addr_d at the edge ending RD, and rdata is valid throughout RDW.

## Test plan
- **Load extension:** mem[0x40] = 0x80FF7F01.
  - LB at 0x40 → 0x00000001.
  - LB at 0x42 → 0xFFFFFFFF.
  - LBU at 0x43 → 0x00000080.
  - LH at 0x42 → 0xFFFF80FF.
  - LHU at 0x40 → 0x00007F01.
  - LW → 0x80FF7F01.
  - Each has resp_valid exactly 3 cycles after acceptance.
- **SH read-modify-write:** mem[0x100] = 0x11223344; SH at 0x102 with wdata 0xAAAABEEF.
  - Exactly one wen pulse, in cycle 3, with addr_d = 0x100 and wdata = 0xBEEF3344.
  - A following LW returns 0xBEEF3344.
- **SB to every lane:** mem[0x10] = 0, then SB 0x5A to 0x10–0x13 in turn.
  - The final LW returns 0x5A5A5A5A, and each intermediate word is correct.
- **Errors:**
  - LW at 0x21, SH at 0x33, funct3 = 011: each gives resp_err = 1 one cycle after acceptance, resp_rdata = 0, wen never asserted.
  - SW at 0x20 then succeeds with resp_err = 0.
- **Reset during RMW:** assert rst in the RDW cycle of an SB.
  - wen is never asserted and no resp_valid is produced.
  - The memory word is unchanged, and req_ready = 1 on the first cycle after rst deasserts.
- **Back-to-back requests:** hold req_valid high with 8 mixed requests.
  - Each is accepted only in IDLE, responses come in order, one response per request, with no request lost or duplicated.

Source files
------------

// File: rtl/data_access_unit_if.sv
// Bundle of the core request/response handshake and the block-RAM data port
// seen by data_access_unit.
interface data_access_unit_if;
  localparam int WORD_LEN = 32;

  logic                req_valid;
  logic                req_ready;
  logic                req_wen;
  logic [2:0]          req_funct3;
  logic [WORD_LEN-1:0] req_addr;
  logic [WORD_LEN-1:0] req_wdata;
  logic                resp_valid;
  logic [WORD_LEN-1:0] resp_rdata;
  logic                resp_err;
  logic [WORD_LEN-1:0] addr_d;
  logic [WORD_LEN-1:0] rdata;
  logic                wen;
  logic [WORD_LEN-1:0] wdata;

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata, rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, addr_d, wen, wdata
  );

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata, rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, addr_d, wen, wdata
  );
endinterface

// File: rtl/data_access_unit.sv
// Load/store initiator: sub-word loads with extension, sub-word stores as
// read-modify-write over a word-only block RAM, and alignment/funct3 checking.
module data_access_unit (
  input logic              clk,
  input logic              rst,
  data_access_unit_if.slave bus
);
  localparam int WORD_LEN = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                is_store_r;
  logic [2:0]          funct3_r;
  logic [1:0]          offset_r;
  logic [WORD_LEN-1:0] store_data_r;
  logic [WORD_LEN-1:0] addr_d_r;
  logic [WORD_LEN-1:0] wdata_r;
  logic [WORD_LEN-1:0] resp_rdata_r;
  logic                resp_valid_r;
  logic                resp_err_r;
  logic                wen_r;
  logic                accept_s;
  logic                illegal_s;
  logic [WORD_LEN-1:0] load_word_s;
  logic [WORD_LEN-1:0] merge_word_s;

  function automatic logic is_illegal(input logic st, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = st;
      F3_HU:   bad = st | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [WORD_LEN-1:0] extend_load(input logic [WORD_LEN-1:0] word,
                                                      input logic [2:0] f3,
                                                      input logic [1:0] off);
    logic [7:0]          b;
    logic [15:0]         h;
    logic [WORD_LEN-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'h000000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Only the addressed lane takes store data; the rest keep the old word.
  function automatic logic [WORD_LEN-1:0] merge_store(input logic [WORD_LEN-1:0] word,
                                                      input logic [WORD_LEN-1:0] data,
                                                      input logic [2:0] f3,
                                                      input logic [1:0] off);
    logic [WORD_LEN-1:0] r;
    r = word;
    case (f3[1:0])
      2'b00: r[{off, 3'b000} +: 8] = data[7:0];
      2'b01: begin
        if (off[1]) r[31:16] = data[15:0];
        else        r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  assign bus.req_ready  = (state_r == IDLE) && !rst;
  assign bus.wen        = wen_r && !rst;
  assign bus.addr_d     = addr_d_r;
  assign bus.wdata      = wdata_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

  assign accept_s     = bus.req_valid && bus.req_ready;
  assign illegal_s    = is_illegal(bus.req_wen, bus.req_funct3, bus.req_addr[1:0]);
  assign load_word_s  = extend_load(bus.rdata, funct3_r, offset_r);
  assign merge_word_s = merge_store(bus.rdata, store_data_r, funct3_r, offset_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                           state_next_s = IDLE;
        else if (illegal_s)                      state_next_s = RESP;
        else if (!bus.req_wen)                   state_next_s = RD;
        else if (bus.req_funct3[1:0] == 2'b10)   state_next_s = WR;
        else                                     state_next_s = RD;
      end
      RD:      state_next_s = RDW;
      RDW: begin
        if (is_store_r) state_next_s = WR;
        else            state_next_s = RESP;
      end
      WR:      state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request latch, memory-port registers and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_r   <= 1'b0;
      funct3_r     <= 3'b000;
      offset_r     <= 2'b00;
      store_data_r <= 32'h0000_0000;
      addr_d_r     <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      resp_rdata_r <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      wen_r        <= 1'b0;
    end else begin
      resp_valid_r <= (state_next_s == RESP);
      wen_r        <= (state_next_s == WR);
      if (accept_s) begin
        is_store_r   <= bus.req_wen;
        funct3_r     <= bus.req_funct3;
        offset_r     <= bus.req_addr[1:0];
        store_data_r <= bus.req_wdata;
        addr_d_r     <= {bus.req_addr[31:2], 2'b00};
        if (bus.req_wen && !illegal_s && (bus.req_funct3[1:0] == 2'b10))
          wdata_r <= bus.req_wdata;
      end
      if ((state_r == RDW) && is_store_r) wdata_r <= merge_word_s;
      // Response fields change only on entry to RESP and hold otherwise.
      if (state_next_s == RESP) begin
        case (state_r)
          IDLE: begin
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b1;
          end
          RDW: begin
            resp_rdata_r <= load_word_s;
            resp_err_r   <= 1'b0;
          end
          default: begin
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_access_unit.sv
// Scoreboard bench for data_access_unit: stimulus pushes expected responses and
// writes; independent monitors pop and compare when the DUT presents them.
module tb_data_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t exp_resp[$];
  wr_t   exp_wr[$];
  logic [31:0] mem [0:127];

  data_access_unit_if bus();

  data_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Block-RAM model: one-cycle registered read, whole-word write.
  always @(posedge clk) begin
    if (preload) begin
      mem[4]  <= 32'h0000_0000;
      mem[8]  <= 32'h0000_0000;
      mem[16] <= 32'h80FF_7F01;
      mem[24] <= 32'h1234_5678;
      mem[32] <= 32'hDEAD_BEEF;
      mem[64] <= 32'h1122_3344;
    end else if (bus.wen) begin
      mem[bus.addr_d[8:2]] <= bus.wdata;
    end
    bus.rdata <= mem[bus.addr_d[8:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (exp_resp.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = exp_resp.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
      end
    end
  end

  // Memory write monitor.
  always @(negedge clk) begin
    if (bus.wen === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_wen", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wen_cycle", cyc, w.cyc);
        chk("wen_addr", bus.addr_d, w.addr);
        chk("wen_wdata", bus.wdata, w.data);
      end
    end
  end

  // Called at a negedge; leaves req_valid high on return (next negedge).
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ee,
                       input int lat, input logic hw, input logic [31:0] ewd, input int wlat);
    int guard;
    guard = 0;
    bus.req_valid  = 1'b1;
    bus.req_wen    = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_resp.push_back('{cyc: cyc + lat, rdata: er, err: ee});
      if (hw) exp_wr.push_back('{cyc: cyc + wlat, addr: {a[31:2], 2'b00}, data: ewd});
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    bus.req_valid = 1'b0;
    while ((exp_resp.size() != 0 || exp_wr.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_resp.size() != 0 || exp_wr.size() != 0) begin
      chk("drain_timeout", 32'd0, 32'd1);
      exp_resp.delete();
      exp_wr.delete();
    end
    @(negedge clk);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] er);
    issue(1'b0, f3, a, 32'h0, er, 1'b0, 3, 1'b0, 32'h0, 0);
    wait_idle();
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_wen", {31'd0, bus.wen}, 32'd0);
    chk("rst_addr_d", bus.addr_d, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    rst = 1'b0;
    preload = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);

    // Load extension on 0x80FF7F01
    load(3'b000, 32'h40, 32'h0000_0001);
    load(3'b000, 32'h42, 32'hFFFF_FFFF);
    load(3'b100, 32'h43, 32'h0000_0080);
    load(3'b001, 32'h42, 32'hFFFF_80FF);
    load(3'b101, 32'h40, 32'h0000_7F01);
    load(3'b010, 32'h40, 32'h80FF_7F01);

    // SH read-modify-write
    issue(1'b1, 3'b001, 32'h102, 32'hAAAA_BEEF, 32'h0, 1'b0, 4, 1'b1, 32'hBEEF_3344, 3);
    wait_idle();
    load(3'b010, 32'h100, 32'hBEEF_3344);

    // SB into each lane; high wdata bits must be ignored
    issue(1'b1, 3'b000, 32'h10, 32'h1234_565A, 32'h0, 1'b0, 4, 1'b1, 32'h0000_005A, 3);
    wait_idle();
    issue(1'b1, 3'b000, 32'h11, 32'h1234_565A, 32'h0, 1'b0, 4, 1'b1, 32'h0000_5A5A, 3);
    wait_idle();
    issue(1'b1, 3'b000, 32'h12, 32'h1234_565A, 32'h0, 1'b0, 4, 1'b1, 32'h005A_5A5A, 3);
    wait_idle();
    issue(1'b1, 3'b000, 32'h13, 32'h1234_565A, 32'h0, 1'b0, 4, 1'b1, 32'h5A5A_5A5A, 3);
    wait_idle();
    load(3'b010, 32'h10, 32'h5A5A_5A5A);

    // Errors: no memory write, response one cycle after acceptance
    issue(1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0);
    wait_idle();
    issue(1'b1, 3'b001, 32'h33, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0);
    wait_idle();
    issue(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0);
    wait_idle();
    issue(1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0);
    wait_idle();
    issue(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1'b1, 32'hCAFE_F00D, 1);
    wait_idle();
    load(3'b010, 32'h20, 32'hCAFE_F00D);

    // Reset asserted in the RDW cycle of an SB: no write, no response
    bus.req_valid  = 1'b1;
    bus.req_wen    = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h61;
    bus.req_wdata  = 32'h0000_00AB;
    chk("rmw_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rmw_rst", {31'd0, bus.req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("mem_unchanged", mem[24], 32'h1234_5678);
    load(3'b010, 32'h60, 32'h1234_5678);

    // Back-to-back with req_valid held high
    issue(1'b0, 3'b010, 32'h80, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 32'h0, 0);
    issue(1'b1, 3'b000, 32'h81, 32'h0000_0011, 32'h0, 1'b0, 4, 1'b1, 32'hDEAD_11EF, 3);
    issue(1'b0, 3'b100, 32'h81, 32'h0, 32'h0000_0011, 1'b0, 3, 1'b0, 32'h0, 0);
    issue(1'b0, 3'b001, 32'h82, 32'h0, 32'hFFFF_DEAD, 1'b0, 3, 1'b0, 32'h0, 0);
    issue(1'b1, 3'b001, 32'h80, 32'h0000_7777, 32'h0, 1'b0, 4, 1'b1, 32'hDEAD_7777, 3);
    issue(1'b0, 3'b010, 32'h80, 32'h0, 32'hDEAD_7777, 1'b0, 3, 1'b0, 32'h0, 0);
    issue(1'b0, 3'b000, 32'h83, 32'h0, 32'hFFFF_FFDE, 1'b0, 3, 1'b0, 32'h0, 0);
    issue(1'b0, 3'b010, 32'h85, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0);
    wait_idle();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
